// File: rtl/dfe_cfg_pkg.sv
// dfe_cfg_pkg: shared target/state types and bank depth helpers for the coefficient loader
package dfe_cfg_pkg;
  localparam int unsigned N_TAP = 72;
  localparam int unsigned COEFF_DEPTH = 5;
  typedef enum logic [1:0] {FRAC_DEC, IIR_1MHZ, IIR_2MHZ, IIR_2_4MHZ} cfg_target_e;
  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_SETTLE, S_VERIFY} ctrl_state_e;
  function automatic int unsigned target_depth(cfg_target_e t, int unsigned n_tap);
    return t == FRAC_DEC ? n_tap : COEFF_DEPTH;
  endfunction
endpackage

// File: rtl/coeff_bank.sv
// coeff_bank: one shadow coefficient bank with a single write port and a readback compare
module coeff_bank #(
  parameter int unsigned DEPTH = 5,
  parameter int W = 20,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we_i,
  input  logic [AW-1:0] addr_i,
  input  logic signed [W-1:0] data_i,
  output logic signed [W-1:0] coeff_o [DEPTH],
  input  logic signed [W-1:0] rb_i [DEPTH],
  output logic mismatch_o
);
  always_ff @(posedge clk) begin
    if (!rst_n) coeff_o <= '{default: '0};
    else if (we_i) coeff_o[addr_i] <= data_i;
  end
  assign mismatch_o = coeff_o != rb_i;
endmodule

// File: rtl/coeff_load_ctrl.sv
// coeff_load_ctrl: streams coefficient words into shadow banks, strobes the
// target filter on the closing word and checks its readback two cycles later
module coeff_load_ctrl #(
  parameter int COEFF_WIDTH = 20,
  parameter int unsigned N_TAP = 72
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_valid,
  output logic cfg_ready,
  input  logic [1:0] cfg_target,
  input  logic [$clog2(N_TAP)-1:0] cfg_addr,
  input  logic signed [COEFF_WIDTH-1:0] cfg_data,
  input  logic cfg_last,
  output logic [3:0] coeff_wr_en,
  output logic signed [COEFF_WIDTH-1:0] frac_dec_coeff_o [N_TAP],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_1MHz_o [dfe_cfg_pkg::COEFF_DEPTH],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_2MHz_o [dfe_cfg_pkg::COEFF_DEPTH],
  output logic signed [COEFF_WIDTH-1:0] iir_coeff_2_4MHz_o [dfe_cfg_pkg::COEFF_DEPTH],
  input  logic signed [COEFF_WIDTH-1:0] frac_dec_coeff_rb [N_TAP],
  input  logic signed [COEFF_WIDTH-1:0] iir_coeff_1MHz_rb [dfe_cfg_pkg::COEFF_DEPTH],
  input  logic signed [COEFF_WIDTH-1:0] iir_coeff_2MHz_rb [dfe_cfg_pkg::COEFF_DEPTH],
  input  logic signed [COEFF_WIDTH-1:0] iir_coeff_2_4MHz_rb [dfe_cfg_pkg::COEFF_DEPTH],
  output logic done,
  output logic addr_err,
  output logic verify_err
);
  import dfe_cfg_pkg::*;
  localparam int IW = $clog2(COEFF_DEPTH);
  ctrl_state_e state_q, state_d;
  logic [1:0] target_q, target_d;
  logic [3:0] wr_en_d, we, mismatch;
  logic hs, last_hs, in_range;
  assign cfg_ready = state_q == S_IDLE;
  assign hs = cfg_valid && cfg_ready;
  assign last_hs = hs && cfg_last;
  assign in_range = 32'(cfg_addr) < target_depth(cfg_target_e'(cfg_target), N_TAP);
  assign we = (hs && in_range) ? 4'b0001 << cfg_target : 4'b0000;
  assign wr_en_d = last_hs ? 4'b0001 << cfg_target : 4'b0000;
  assign target_d = last_hs ? cfg_target : target_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = last_hs ? S_COMMIT : S_IDLE;
      S_COMMIT: state_d = S_SETTLE;
      S_SETTLE: state_d = S_VERIFY;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      target_q <= '0;
      coeff_wr_en <= '0;
      addr_err <= 1'b0;
    end else begin
      state_q <= state_d;
      target_q <= target_d;
      coeff_wr_en <= wr_en_d;
      addr_err <= hs && !in_range;
    end
  end
  // only the bank named by the closing word is judged; others may be mid-load
  assign done = state_q == S_VERIFY;
  assign verify_err = done && mismatch[target_q];
  coeff_bank #(.DEPTH(N_TAP), .W(COEFF_WIDTH)) u_frac (
    .clk(clk), .rst_n(rst_n), .we_i(we[0]), .addr_i(cfg_addr), .data_i(cfg_data),
    .coeff_o(frac_dec_coeff_o), .rb_i(frac_dec_coeff_rb), .mismatch_o(mismatch[0])
  );
  coeff_bank #(.DEPTH(COEFF_DEPTH), .W(COEFF_WIDTH)) u_iir1 (
    .clk(clk), .rst_n(rst_n), .we_i(we[1]), .addr_i(cfg_addr[IW-1:0]), .data_i(cfg_data),
    .coeff_o(iir_coeff_1MHz_o), .rb_i(iir_coeff_1MHz_rb), .mismatch_o(mismatch[1])
  );
  coeff_bank #(.DEPTH(COEFF_DEPTH), .W(COEFF_WIDTH)) u_iir2 (
    .clk(clk), .rst_n(rst_n), .we_i(we[2]), .addr_i(cfg_addr[IW-1:0]), .data_i(cfg_data),
    .coeff_o(iir_coeff_2MHz_o), .rb_i(iir_coeff_2MHz_rb), .mismatch_o(mismatch[2])
  );
  coeff_bank #(.DEPTH(COEFF_DEPTH), .W(COEFF_WIDTH)) u_iir3 (
    .clk(clk), .rst_n(rst_n), .we_i(we[3]), .addr_i(cfg_addr[IW-1:0]), .data_i(cfg_data),
    .coeff_o(iir_coeff_2_4MHz_o), .rb_i(iir_coeff_2_4MHz_rb), .mismatch_o(mismatch[3])
  );
endmodule

// File: tb/tb_coeff_load_ctrl.sv
// tb_coeff_load_ctrl: directed and randomized stimulus checked every cycle against
// an event-timeline model of the loader plus a filter model that echoes its bank
module tb_coeff_load_ctrl;
  logic clk = 0, rst_n = 0, cfg_valid = 0, cfg_last = 0;
  logic [1:0] cfg_target = 0;
  logic [6:0] cfg_addr = 0;
  logic signed [19:0] cfg_data = 0;
  logic cfg_ready, done, addr_err, verify_err;
  logic [3:0] coeff_wr_en;
  logic signed [19:0] frac_o [72], i1_o [5], i2_o [5], i3_o [5];
  logic signed [19:0] frac_rb [72], i1_rb [5], i2_rb [5], i3_rb [5];
  int checks = 0, errors = 0, cyc = 0;
  // model: shadow contents plus the edge of the last committing word and last dropped word
  logic signed [19:0] m_bank [4][72];
  int last_edge = -100, last_tgt = 0, aerr_edge = -100;
  bit last_corrupt = 0, corrupt = 0;
  int w, e, e0;

  always #5 clk = ~clk;

  coeff_load_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_target(cfg_target), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
    .coeff_wr_en(coeff_wr_en), .frac_dec_coeff_o(frac_o), .iir_coeff_1MHz_o(i1_o),
    .iir_coeff_2MHz_o(i2_o), .iir_coeff_2_4MHz_o(i3_o), .frac_dec_coeff_rb(frac_rb),
    .iir_coeff_1MHz_rb(i1_rb), .iir_coeff_2MHz_rb(i2_rb), .iir_coeff_2_4MHz_rb(i3_rb),
    .done(done), .addr_err(addr_err), .verify_err(verify_err)
  );

  // filter model: registered copy of the bank on its write strobe, optionally corrupting tap 17
  always @(posedge clk) begin
    if (!rst_n) begin
      frac_rb <= '{default: '0};
      i1_rb <= '{default: '0};
      i2_rb <= '{default: '0};
      i3_rb <= '{default: '0};
    end else begin
      if (coeff_wr_en[0]) begin
        frac_rb <= frac_o;
        if (corrupt) frac_rb[17] <= frac_o[17] ^ 20'sd1;
      end
      if (coeff_wr_en[1]) i1_rb <= i1_o;
      if (coeff_wr_en[2]) i2_rb <= i2_o;
      if (coeff_wr_en[3]) i3_rb <= i3_o;
    end
  end

  function automatic int depth(input int t);
    return t == 0 ? 72 : 5;
  endfunction

  // cycle c is the interval after edge c; a committing word at edge t blocks cycles t..t+2
  function automatic bit exp_ready(input int c);
    return !(c >= last_edge && c <= last_edge + 2);
  endfunction

  function automatic int fd72(input logic signed [19:0] a [72]);
    for (int i = 0; i < 72; i++) if (a[i] !== m_bank[0][i]) return i;
    return 0;
  endfunction

  function automatic int fd5(input logic signed [19:0] a [5], input int k);
    for (int i = 0; i < 5; i++) if (a[i] !== m_bank[k][i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_bank = '{default: '0};
      last_edge = -100;
      aerr_edge = -100;
    end else if (cfg_valid && exp_ready(cyc - 1)) begin
      if (int'(cfg_addr) < depth(int'(cfg_target))) m_bank[int'(cfg_target)][int'(cfg_addr)] = cfg_data;
      else aerr_edge = cyc;
      if (cfg_last) begin
        last_edge = cyc;
        last_tgt = int'(cfg_target);
        last_corrupt = corrupt && cfg_target == 2'd0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (cyc >= 1) begin
      chk("cfg_ready", 32'(cfg_ready), 32'(exp_ready(cyc)));
      chk("coeff_wr_en", 32'(coeff_wr_en), cyc == last_edge ? 32'd1 << last_tgt : 32'd0);
      chk("done", 32'(done), 32'(cyc == last_edge + 2));
      chk("verify_err", 32'(verify_err), 32'(cyc == last_edge + 2 && last_corrupt));
      chk("addr_err", 32'(addr_err), 32'(cyc == aerr_edge));
      chk("frac_bank", 32'(frac_o[fd72(frac_o)]), 32'(m_bank[0][fd72(frac_o)]));
      chk("iir1_bank", 32'(i1_o[fd5(i1_o, 1)]), 32'(m_bank[1][fd5(i1_o, 1)]));
      chk("iir2_bank", 32'(i2_o[fd5(i2_o, 2)]), 32'(m_bank[2][fd5(i2_o, 2)]));
      chk("iir3_bank", 32'(i3_o[fd5(i3_o, 3)]), 32'(m_bank[3][fd5(i3_o, 3)]));
    end
  end

  // called in the +2 phase of a cycle; returns in the +2 phase of the cycle after the handshake edge
  task automatic send(input int t, input int a, input int d, input bit last, output int waited, output int hs_edge);
    cfg_valid = 1;
    cfg_target = 2'(t);
    cfg_addr = 7'(a);
    cfg_data = 20'(d);
    cfg_last = last;
    waited = 0;
    while (!cfg_ready && waited < 20) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (waited >= 20) chk("ready_timeout", 32'(cfg_ready), 32'd1);
    @(posedge clk);
    #2;
    hs_edge = cyc;
    cfg_valid = 0;
    cfg_last = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) step();
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_wr_en", 32'(coeff_wr_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_frac0", 32'(frac_o[0]), 32'd0);
    chk("rst_iir3_4", 32'(i3_o[4]), 32'd0);
    rst_n = 1;
    step();
    for (int i = 0; i < 5; i++) send(1, i, i + 1, i == 4, w, e);
    chk("iir_wr_en_t1", 32'(coeff_wr_en), 32'h2);
    chk("iir_ready_t1", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 5; i++) chk("iir_bank_lit", 32'(i1_o[i]), 32'(i + 1));
    step();
    chk("iir_wr_en_t2", 32'(coeff_wr_en), 32'd0);
    step();
    chk("iir_done_t3", 32'(done), 32'd1);
    chk("iir_verr_t3", 32'(verify_err), 32'd0);
    step();
    chk("iir_ready_t4", 32'(cfg_ready), 32'd1);
    send(0, 72, 'h7FFFF, 0, w, e);
    chk("oor_addr_err", 32'(addr_err), 32'd1);
    chk("oor_ready", 32'(cfg_ready), 32'd1);
    chk("oor_frac0", 32'(frac_o[0]), 32'd0);
    step();
    chk("oor_addr_err_clr", 32'(addr_err), 32'd0);
    corrupt = 1;
    for (int i = 0; i < 72; i++) send(0, i, int'($urandom), i == 71, w, e);
    chk("cor_wr_en", 32'(coeff_wr_en), 32'h1);
    step();
    step();
    chk("cor_done", 32'(done), 32'd1);
    chk("cor_verr", 32'(verify_err), 32'd1);
    step();
    corrupt = 0;
    send(2, 0, 111, 1, w, e0);
    send(2, 1, 222, 0, w, e);
    chk("bp_wait", 32'(w), 32'd3);
    chk("bp_edge", 32'(e - e0), 32'd4);
    chk("bp_word0", 32'(i2_o[0]), 32'd111);
    chk("bp_word1", 32'(i2_o[1]), 32'd222);
    send(3, 0, 5, 1, w, e);
    step();
    rst_n = 0;
    step();
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_verr", 32'(verify_err), 32'd0);
    chk("mid_rst_iir2", 32'(i2_o[1]), 32'd0);
    rst_n = 1;
    step();
    chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 0;
        step();
        rst_n = 1;
      end else if ($urandom_range(0, 4) == 0) begin
        step();
      end else begin
        int t, a;
        t = int'($urandom_range(0, 3));
        a = t == 0 ? int'($urandom_range(0, 80)) : int'($urandom_range(0, 7));
        send(t, a, int'($urandom), $urandom_range(0, 7) == 0, w, e);
      end
    end
    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/coeff_load_ctrl.md
# coeff_load_ctrl

Coefficient load controller for the DFE filter core. It accepts a stream of coefficient words over a valid/ready configuration port and writes them into per-filter shadow banks. On the last word of a block it pulses the write enable of the target filter: the fractional decimator or one of the three IIR notch stages. It then verifies the filter's coefficient readback against the shadow bank. It sits between the register/host interface and the core's `*_coeff_wr_en` / `*_coeff_data_in` / `*_coeff_data_out` ports.

## Interface
- `COEFF_WIDTH`, 20: coefficient word width, signed.
- `N_TAP`, 72: fractional decimator tap count.
- `COEFF_DEPTH`, 5: IIR biquad coefficient count (3 numerator + 2 denominator); localparam.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `cfg_valid` in 1: config word valid.
- `cfg_ready` out 1: controller can accept a word.
- `cfg_target` in 2: 0 = frac dec, 1 = IIR 1 MHz, 2 = IIR 2 MHz, 3 = IIR 2.4 MHz.
- `cfg_addr` in `$clog2(N_TAP)`: coefficient index within the target.
- `cfg_data` in `COEFF_WIDTH` signed: coefficient value.
- `cfg_last` in 1: this word closes the block and triggers a commit.
- `coeff_wr_en` out 4: one-hot write strobe, bit index = target code.
- `frac_dec_coeff_o` out `[N_TAP]` x `COEFF_WIDTH`: frac dec shadow bank.
- `iir_coeff_1MHz_o`, `iir_coeff_2MHz_o`, `iir_coeff_2_4MHz_o` out `[COEFF_DEPTH]` x `COEFF_WIDTH`: IIR shadow banks.
- `frac_dec_coeff_rb` in `[N_TAP]` x `COEFF_WIDTH`: frac dec readback.
- `iir_coeff_1MHz_rb`, `iir_coeff_2MHz_rb`, `iir_coeff_2_4MHz_rb` in `[COEFF_DEPTH]` x `COEFF_WIDTH`: IIR readback.
- `done` out 1: one-cycle pulse when verify completes.
- `addr_err` out 1: one-cycle pulse when an out-of-range word is dropped.
- `verify_err` out 1: one-cycle pulse, coincident with `done`, when readback differs from the shadow bank.

## Operation
- The FSM is one of IDLE, COMMIT, SETTLE, VERIFY.
- **IDLE:** `cfg_ready` = 1. A handshake is `cfg_valid && cfg_ready`.
  - On handshake with `cfg_addr` < depth(`cfg_target`): `shadow[target][addr] <= cfg_data`.
  - Depth is `N_TAP` for target 0 and `COEFF_DEPTH` for targets 1 to 3.
  - Out-of-range address: the word is dropped and `addr_err` pulses next cycle.
  - Handshake with `cfg_last`: latch the target and go to COMMIT. This happens even if the same word was dropped for range.
- **COMMIT (1 cycle):** `cfg_ready` = 0 and `coeff_wr_en[latched target]` = 1. The whole bank is written, so entries not loaded this block keep their previous shadow value (0 after reset).
- **SETTLE (1 cycle):** wait for the filter's registered readback.
- **VERIFY (1 cycle):** compare every entry of the latched bank against its readback. `done` = 1, `verify_err` = 1 on any mismatch. Then return to IDLE.
- Blocks may interleave words for different targets before `cfg_last`. The commit strobes only the target of the `cfg_last` word; the other shadow banks hold their values until their own commit.
- `cfg_valid` while `cfg_ready` = 0 is not consumed. The source must hold the word until the handshake.
- **Reset:**
  - All shadow banks = 0.
  - State = IDLE, `cfg_ready` = 1.
  - `coeff_wr_en`, `done`, `addr_err`, `verify_err` = 0.
  - Reset asserted in any state aborts the block: no strobe and no `done` for it.

## Timing
- Word handshake at edge t: the shadow entry is visible on `*_o` after edge t.
- `cfg_last` handshake at edge t:
  - `coeff_wr_en` high in cycle t+1, exactly one cycle.
  - `done` / `verify_err` valid in cycle t+3.
  - `cfg_ready` back high in cycle t+4.
- Throughput in IDLE: one word per cycle. The `cfg_last` word costs 3 dead cycles.
- `addr_err` comes from a register: it is high in the cycle after the offending handshake.
- The readback compare is combinational inside VERIFY. All other outputs are registered.

## Structure
- Package `dfe_cfg_pkg` holds:
  - `cfg_target_e` (FRAC_DEC, IIR_1MHZ, IIR_2MHZ, IIR_2_4MHZ) and `ctrl_state_e`.
  - The `COEFF_DEPTH` / `N_TAP` depth constants and a `target_depth()` function.
- One sub-module, `coeff_bank`: parameterised depth, write port (en/addr/data), full-array output, and a readback-compare `mismatch` output. It is instantiated four times: once with depth `N_TAP`, three times with depth `COEFF_DEPTH`.

## Test plan
- **Reset:** assert `rst_n` = 0 for 2 cycles → all `*_o` = 0, `cfg_ready` = 1, `coeff_wr_en` = 0, `done` = 0.
- **IIR load with ideal readback:** target 1, addrs 0..4, data 1..5, `cfg_last` on addr 4 (handshake at t) → `coeff_wr_en` = 4'b0010 in cycle t+1 only; `iir_coeff_1MHz_o` = {1,2,3,4,5} by index; `done` = 1 at t+3; `verify_err` = 0 (readback model echoes after `wr_en`).
- **Out of range:** target 0, addr 72, data 0x7FFFF → `addr_err` pulse next cycle; `frac_dec_coeff_o` unchanged; no FSM transition.
- **Corrupted readback:** load all 72 frac dec taps; the readback model corrupts tap 17 → `coeff_wr_en` = 4'b0001 once; `done` = 1 and `verify_err` = 1 in the same cycle.
- **Backpressure:** hold `cfg_valid` with the next word through COMMIT/SETTLE/VERIFY → `cfg_ready` = 0 for 3 cycles; the word is accepted exactly once in the cycle `cfg_ready` returns.
- **Reset mid-operation:** `rst_n` = 0 during SETTLE → no `done` / `verify_err`; banks = 0; `cfg_ready` = 1 in the first cycle after reset release.
